management_irq_controller: RTL and testbench
============================================

// Module: management_irq_controller
// PURPOSE
// - APB completer on the management smol bus. Aggregates up to NUM_IRQ single-bit interrupt sources from sys_clk-domain
//   blocks (Ethernet RX frame ready, flash, crypt, ...) into the one irq pin to the MCU.
// - Replaces the plain OR of sources with per-source enable, edge/level mode, W1C pending and software force.
// - Adds a holdoff timer so the irq pin cannot re-fire faster than software can service it.
// PARAMETERS
// - NUM_IRQ       16  number of sources, 1..16; bits [15:NUM_IRQ] of every register read 0 and ignore writes
// - ADDR_WIDTH    10  APB byte-address width; decode uses paddr[4:1], upper bits ignored
// - HOLDOFF_INIT  0   reset value of the HOLDOFF register; 0 = holdoff disabled
// PORTS
// - clk         in   1           sys_clk domain; APB and all sources are synchronous to it
// - rst         in   1           synchronous, active-high reset
// - psel        in   1           APB select
// - penable     in   1           APB access phase
// - pwrite      in   1           1 = write
// - paddr       in   ADDR_WIDTH  byte address
// - pwdata      in   16          write data
// - prdata      out  16          read data, valid while pready=1
// - pready      out  1           one-cycle completion strobe
// - pslverr     out  1           error flag, qualified by pready
// - irq_src     in   NUM_IRQ     raw source lines, active high
// - irq         out  1           registered interrupt output to MCU
// BEHAVIOUR
// - Reset: prdata=0, pready=0, pslverr=0, irq=0, PENDING=0, ENABLE=0, MODE=0, cnt=0, src_q=0, HOLDOFF=HOLDOFF_INIT.
// - APB: exactly one wait state.
//   - An access phase (psel&penable&!pready) is seen in cycle N; pready=1 for exactly cycle N+1, then 0.
//   - Register write and read sampling happen at cycle N.
//   - prdata holds the read value during the pready cycle; it is 0 on writes.
// - Register map (byte offset):
//   - 0x00 RAW, RO: irq_src.
//   - 0x02 PENDING, R/W1C.
//   - 0x04 ENABLE, RW.
//   - 0x06 MODE, RW: 1 = edge, 0 = level.
//   - 0x08 HOLDOFF, RW, 16 bit: holdoff length in cycles.
//   - 0x0A FORCE, WO: 1 bits set PENDING; reads 0.
// - pslverr=1 for offsets >= 0x0C, and for writes to RAW. The access still completes with pready; there are no side effects.
// - Source capture: src_q is irq_src registered each cycle.
//   - Edge mode: set_i = irq_src[i] & ~src_q[i] (rising edge).
//   - Level mode: set_i = irq_src[i].
// - PENDING next = (PENDING & ~w1c) | set | force. Set/force beat a same-cycle W1C.
//   - Level source still high: a W1C clear is overridden, so the bit stays 1.
// - MODE change does not touch PENDING. src_q keeps updating, so no spurious edge is produced on a mode switch.
// - ENABLE masks only irq; PENDING latches regardless of ENABLE.
// - active = |(PENDING & ENABLE), evaluated on the registered PENDING/ENABLE.
// - irq next = active & (cnt == 0). Latency: source edge in cycle N -> PENDING in N+1 -> irq in N+2.
// - Holdoff counter cnt, 16 bit:
//   - On irq falling (irq=1, next=0): cnt loads HOLDOFF.
//   - Otherwise, if cnt != 0: cnt decrements by 1 and saturates at 0.
//   - A HOLDOFF write does not alter a running cnt.
//   - With HOLDOFF=0, irq may re-assert 2 cycles after the W1C access phase.
// - Reset mid-transaction: pready is dropped and the access is abandoned with no register effect. The host re-issues it.
// STRUCTURE
// - Shared package (MgmtIrqPkg):
//   - typedef enum of register offsets: IRQ_REG_RAW=0x00 .. IRQ_REG_FORCE=0x0A.
//   - Source bit indices: IRQ_ETH_RX=0, IRQ_FLASH=1, IRQ_CRYPT=2. Firmware headers are generated from these.
// - One sub-module, irq_holdoff_timer (clk, rst, load, load_val, zero): isolates the counter for unit test.
// - APB decode, the PENDING/ENABLE/MODE regs and the irq register live in the top module.
// TESTING
// - Edge source: MODE=1, ENABLE=1; pulse irq_src[0] for 1 cycle -> PENDING=0x0001, irq=1 two cycles later.
//   W1C 0x0001 -> irq=0 in cycle N+2.
// - Level source: MODE=0, ENABLE=0x0002; hold irq_src[1]=1, W1C 0x0002 -> PENDING stays 0x0002 and irq stays 1.
//   Drop the source, then W1C -> PENDING=0, irq=0.
// - Mask: ENABLE=0, pulse src 3 -> PENDING=0x0008, irq=0.
//   Write ENABLE=0x0008 -> irq=1 two cycles after the write access phase.
// - Holdoff: HOLDOFF=100; clear a pending edge, re-pulse the source 10 cycles later -> PENDING sets at once.
//   irq stays 0 until cnt expires, i.e. 101 cycles after the fall.
// - Collision: a W1C of bit 0 in the same cycle as a new rising edge on src 0 -> PENDING bit 0 stays 1.
//   Also: FORCE=0x8000 with NUM_IRQ=16 -> bit 15 set.
// - APB errors: read 0x0C -> pready=1, pslverr=1, prdata=0. Write RAW -> pslverr=1, RAW unchanged.
//   Assert rst during the wait state -> pready=0 the next cycle, all registers at reset values.

Source files
------------

// File: rtl/management_irq_controller_pkg.sv
// rtl/management_irq_controller_pkg.sv - shared register map and source indices for the irq controller
//
// Purpose: register byte offsets, source bit positions and decode helpers
// shared by the controller RTL, its bench and the generated firmware headers.
package management_irq_controller_pkg;

  localparam int IRQ_DATA_WIDTH = 16;

  // Byte offsets of the management registers; decode only looks at paddr[4:1].
  typedef enum logic [4:0] {
    IRQ_REG_RAW     = 5'h00,
    IRQ_REG_PENDING = 5'h02,
    IRQ_REG_ENABLE  = 5'h04,
    IRQ_REG_MODE    = 5'h06,
    IRQ_REG_HOLDOFF = 5'h08,
    IRQ_REG_FORCE   = 5'h0A
  } irq_reg_e;

  // Source bit positions wired at the top level of the chip.
  typedef enum int {
    IRQ_ETH_RX = 0,
    IRQ_FLASH  = 1,
    IRQ_CRYPT  = 2
  } irq_src_e;

  // Offsets at 0x0C and above do not exist.
  function automatic logic irq_reg_mapped(input logic [4:0] off);
    return off < 5'h0C;
  endfunction

endpackage

// File: rtl/management_irq_controller_if.sv
// rtl/management_irq_controller_if.sv - APB completer bus bundle for the irq controller
//
// Purpose: groups the APB signals of the management bus.
// Ports (signals): psel, penable, pwrite, paddr[ADDR_WIDTH], pwdata[16] from
// the requester; prdata[16], pready, pslverr from the completer.
interface management_irq_controller_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [15:0]           pwdata;
  logic [15:0]           prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/management_irq_controller_holdoff_timer.sv
// rtl/management_irq_controller_holdoff_timer.sv - irq re-fire holdoff down-counter
//
// Purpose: 16-bit counter loaded when the irq pin falls, counting down to 0.
// Ports: clk, rst (sync, active high); load - take load_val this cycle;
// load_val[16] - holdoff length; zero - counter is 0, irq may fire.
module irq_holdoff_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        zero
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/management_irq_controller.sv
// rtl/management_irq_controller.sv - APB interrupt aggregator with enable, edge/level, W1C, force and holdoff
//
// Purpose: collects NUM_IRQ sys_clk sources into one registered irq pin.
// Ports: clk, rst (sync, active high); apb - APB completer (one wait state);
// irq_src[NUM_IRQ] - raw active-high sources; irq - registered irq to MCU.
module management_irq_controller
  import management_irq_controller_pkg::*;
#(
  parameter int          NUM_IRQ      = 16,
  parameter int          ADDR_WIDTH   = 10,
  parameter logic [15:0] HOLDOFF_INIT = 16'h0000
) (
  input  logic                         clk,
  input  logic                         rst,
  management_irq_controller_if.slave   apb,
  input  logic [NUM_IRQ-1:0]           irq_src,
  output logic                         irq
);

  logic [ADDR_WIDTH-1:0] paddr;
  assign paddr = apb.paddr;

  // Only paddr[4:1] selects a register.
  logic unused_paddr;
  assign unused_paddr = ^{paddr[ADDR_WIDTH-1:5], paddr[0]};

  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] en_q, en_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] src_q, src_d;
  logic [15:0]        hold_q, hold_d;
  logic               pready_q, pready_d;
  logic               pslverr_q, pslverr_d;
  logic [15:0]        prdata_q, prdata_d;
  logic               irq_q, irq_d;

  logic               access;
  logic [4:0]         reg_off;
  logic               bad_access;
  logic               wr_ok;
  logic               rd_ok;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] frc;
  logic [NUM_IRQ-1:0] set;
  logic [15:0]        rdata;
  logic               hold_zero;
  logic               hold_load;

  always_comb begin
    // pready_q blocks a second access phase while the first is completing.
    access     = apb.psel & apb.penable & ~pready_q;
    reg_off    = {paddr[4:1], 1'b0};
    bad_access = ~irq_reg_mapped(reg_off) | (apb.pwrite & (reg_off == IRQ_REG_RAW));
    wr_ok      = access & apb.pwrite & ~bad_access;
    rd_ok      = access & ~apb.pwrite & ~bad_access;

    w1c = '0;
    frc = '0;
    if (wr_ok && reg_off == IRQ_REG_PENDING) w1c = apb.pwdata[NUM_IRQ-1:0];
    if (wr_ok && reg_off == IRQ_REG_FORCE)   frc = apb.pwdata[NUM_IRQ-1:0];

    en_d   = en_q;
    mode_d = mode_q;
    hold_d = hold_q;
    if (wr_ok && reg_off == IRQ_REG_ENABLE)  en_d   = apb.pwdata[NUM_IRQ-1:0];
    if (wr_ok && reg_off == IRQ_REG_MODE)    mode_d = apb.pwdata[NUM_IRQ-1:0];
    if (wr_ok && reg_off == IRQ_REG_HOLDOFF) hold_d = apb.pwdata;

    rdata = 16'h0000;
    case (reg_off)
      IRQ_REG_RAW:     rdata = 16'(irq_src);
      IRQ_REG_PENDING: rdata = 16'(pend_q);
      IRQ_REG_ENABLE:  rdata = 16'(en_q);
      IRQ_REG_MODE:    rdata = 16'(mode_q);
      IRQ_REG_HOLDOFF: rdata = hold_q;
      default:         rdata = 16'h0000;
    endcase

    pready_d  = access;
    pslverr_d = access & bad_access;
    prdata_d  = rd_ok ? rdata : 16'h0000;

    // Edge bits see only rising edges; since src_q tracks regardless of
    // MODE, switching a bit to edge mode never fakes an edge.
    src_d = irq_src;
    set   = (mode_q & irq_src & ~src_q) | (~mode_q & irq_src);

    // New set/force wins over a same-cycle W1C of the same bit.
    pend_d = (pend_q & ~w1c) | set | frc;

    irq_d     = (|(pend_q & en_q)) & hold_zero;
    hold_load = irq_q & ~irq_d;
  end

  irq_holdoff_timer u_holdoff (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (hold_q),
    .zero     (hold_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      en_q      <= '0;
      mode_q    <= '0;
      src_q     <= '0;
      hold_q    <= HOLDOFF_INIT;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 16'h0000;
      irq_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      src_q     <= src_d;
      hold_q    <= hold_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      irq_q     <= irq_d;
    end
  end

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_management_irq_controller.sv
// tb/tb_management_irq_controller.sv - self-checking bench for management_irq_controller
module tb_management_irq_controller;
  import management_irq_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] src;
  logic        irq;

  management_irq_controller_if #(.ADDR_WIDTH(10)) bus ();

  management_irq_controller #(
    .NUM_IRQ(16), .ADDR_WIDTH(10), .HOLDOFF_INIT(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .apb(bus), .irq_src(src), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: register contents plus the edge number from which
  // the holdoff window allows irq again.
  logic [15:0] m_pend, m_en, m_mode, m_hold, m_last, m_prdata;
  logic        m_irq, m_pready, m_slverr;
  longint      cyc = 0;
  longint      irq_ok_from = 0;
  longint      fall_cyc = 0, rise_cyc = 0;
  logic        irq_prev = 1'b0;

  task automatic model_step();
    logic        acc, err, any, nxt;
    logic [4:0]  off;
    logic [15:0] w1c, frc, set;
    if (rst) begin
      m_pend = 0; m_en = 0; m_mode = 0; m_hold = 0; m_last = 0;
      m_irq = 0; m_pready = 0; m_slverr = 0; m_prdata = 0;
      irq_ok_from = 0;
      return;
    end
    acc = bus.psel && bus.penable && !m_pready;
    off = {bus.paddr[4:1], 1'b0};
    err = (off >= 5'h0C) || (bus.pwrite && off == 5'h00);
    w1c = 0; frc = 0;
    m_prdata = 0;
    if (acc && !err && !bus.pwrite) begin
      case (off)
        5'h00: m_prdata = src;
        5'h02: m_prdata = m_pend;
        5'h04: m_prdata = m_en;
        5'h06: m_prdata = m_mode;
        5'h08: m_prdata = m_hold;
        default: m_prdata = 0;
      endcase
    end
    for (int i = 0; i < 16; i++)
      set[i] = m_mode[i] ? (src[i] && !m_last[i]) : src[i];
    any = (m_pend & m_en) != 0;
    nxt = any && (cyc >= irq_ok_from);
    if (m_irq && !nxt) irq_ok_from = cyc + m_hold + 1;
    m_irq = nxt;
    if (acc && !err && bus.pwrite) begin
      case (off)
        5'h02: w1c = bus.pwdata;
        5'h04: m_en = bus.pwdata;
        5'h06: m_mode = bus.pwdata;
        5'h08: m_hold = bus.pwdata;
        5'h0A: frc = bus.pwdata;
        default: ;
      endcase
    end
    m_pend   = (m_pend & ~w1c) | set | frc;
    m_pready = acc;
    m_slverr = acc && err;
    m_last   = src;
  endtask

  // Compare process: every cycle, just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      chk("pready", bus.pready, m_pready);
      if (m_pready) begin
        chk("pslverr", bus.pslverr, m_slverr);
        chk("prdata", bus.prdata, m_prdata);
      end
      chk("irq", irq, m_irq);
      if (irq && !irq_prev) rise_cyc = cyc;
      if (!irq && irq_prev) fall_cyc = cyc;
      irq_prev = irq;
    end
  end

  task automatic apb(input bit wr, input logic [4:0] off, input logic [15:0] wd,
                     output logic [15:0] rd, output logic err,
                     input bit coll = 1'b0, input logic [15:0] coll_src = 16'h0);
    int n;
    @(negedge clk);
    bus.psel = 1; bus.penable = 0; bus.pwrite = wr;
    bus.paddr = {5'($urandom_range(0, 31)), off}; bus.pwdata = wd;
    @(negedge clk);
    bus.penable = 1;
    if (coll) src = coll_src;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.pready && n < 4);
    chk("apb_pready_seen", bus.pready, 1);
    rd = bus.prdata; err = bus.pslverr;
    @(negedge clk);
    bus.psel = 0; bus.penable = 0;
  endtask

  task automatic wr_reg(input logic [4:0] off, input logic [15:0] wd);
    logic [15:0] rd; logic err;
    apb(1'b1, off, wd, rd, err);
  endtask

  task automatic rd_reg(input logic [4:0] off, output logic [15:0] rd);
    logic err;
    apb(1'b0, off, 16'h0, rd, err);
  endtask

  task automatic pulse(input int bitn);
    @(negedge clk); src[bitn] = 1'b1;
    @(negedge clk); src[bitn] = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd;
    logic        err;
    int          n;
    rst = 1; src = 0;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_irq", irq, 0);
    chk("reset_pready", bus.pready, 0);
    chk("reset_prdata", bus.prdata, 0);
    rd_reg(IRQ_REG_PENDING, rd); chk("reset_pending", rd, 16'h0000);
    rd_reg(IRQ_REG_HOLDOFF, rd); chk("reset_holdoff", rd, 16'h0000);

    // Edge source.
    wr_reg(IRQ_REG_MODE, 16'h0001);
    wr_reg(IRQ_REG_ENABLE, 16'h0001);
    pulse(IRQ_ETH_RX);
    chk("edge_irq_before", irq, 0);
    @(posedge clk); #1;
    chk("edge_irq_n2", irq, 1);
    rd_reg(IRQ_REG_PENDING, rd); chk("edge_pending", rd, 16'h0001);
    wr_reg(IRQ_REG_PENDING, 16'h0001);
    chk("w1c_irq_n1", irq, 1);
    @(posedge clk); #1;
    chk("w1c_irq_n2", irq, 0);

    // Level source.
    wr_reg(IRQ_REG_MODE, 16'h0000);
    wr_reg(IRQ_REG_ENABLE, 16'h0002);
    @(negedge clk); src[IRQ_FLASH] = 1'b1;
    repeat (3) @(negedge clk);
    wr_reg(IRQ_REG_PENDING, 16'h0002);
    rd_reg(IRQ_REG_PENDING, rd); chk("level_pending_held", rd, 16'h0002);
    chk("level_irq_held", irq, 1);
    @(negedge clk); src[IRQ_FLASH] = 1'b0;
    wr_reg(IRQ_REG_PENDING, 16'h0002);
    rd_reg(IRQ_REG_PENDING, rd); chk("level_pending_clear", rd, 16'h0000);
    chk("level_irq_clear", irq, 0);

    // Mask.
    wr_reg(IRQ_REG_ENABLE, 16'h0000);
    wr_reg(IRQ_REG_MODE, 16'h0008);
    pulse(3);
    repeat (2) @(negedge clk);
    rd_reg(IRQ_REG_PENDING, rd); chk("mask_pending", rd, 16'h0008);
    chk("mask_irq", irq, 0);
    wr_reg(IRQ_REG_ENABLE, 16'h0008);
    chk("unmask_irq_n1", irq, 0);
    @(posedge clk); #1;
    chk("unmask_irq_n2", irq, 1);
    wr_reg(IRQ_REG_PENDING, 16'h0008);

    // Holdoff.
    wr_reg(IRQ_REG_HOLDOFF, 16'd100);
    wr_reg(IRQ_REG_MODE, 16'h0001);
    wr_reg(IRQ_REG_ENABLE, 16'h0001);
    pulse(0);
    repeat (2) @(negedge clk);
    chk("holdoff_first_irq", irq, 1);
    wr_reg(IRQ_REG_PENDING, 16'h0001);
    repeat (8) @(negedge clk);
    pulse(0);
    rd_reg(IRQ_REG_PENDING, rd); chk("holdoff_pending_set", rd, 16'h0001);
    chk("holdoff_irq_blocked", irq, 0);
    n = 0;
    while (!irq && n < 300) begin @(negedge clk); n++; end
    chk("holdoff_rise_seen", irq, 1);
    chk("holdoff_gap", int'(rise_cyc - fall_cyc), 101);
    wr_reg(IRQ_REG_HOLDOFF, 16'd0);
    wr_reg(IRQ_REG_PENDING, 16'h0001);
    repeat (3) @(negedge clk);

    // Collision of W1C with a fresh rising edge.
    pulse(0);
    repeat (2) @(negedge clk);
    apb(1'b1, IRQ_REG_PENDING, 16'h0001, rd, err, 1'b1, src | 16'h0001);
    @(negedge clk); src[0] = 1'b0;
    rd_reg(IRQ_REG_PENDING, rd); chk("collision_pending", rd, 16'h0001);
    wr_reg(IRQ_REG_FORCE, 16'h8000);
    rd_reg(IRQ_REG_PENDING, rd); chk("force_bit15", rd & 16'h8000, 16'h8000);
    rd_reg(IRQ_REG_FORCE, rd); chk("force_reads_zero", rd, 16'h0000);
    wr_reg(IRQ_REG_PENDING, 16'hFFFF);

    // APB errors.
    apb(1'b0, 5'h0C, 16'h0, rd, err);
    chk("err_rd_slverr", err, 1); chk("err_rd_prdata", rd, 16'h0000);
    apb(1'b1, IRQ_REG_RAW, 16'hFFFF, rd, err);
    chk("err_wr_raw_slverr", err, 1);
    @(negedge clk); src = 16'h0005;
    apb(1'b0, IRQ_REG_RAW, 16'h0, rd, err);
    chk("raw_read", rd, 16'h0005); chk("raw_read_ok", err, 0);
    @(negedge clk); src = 16'h0000;

    // Reset during the wait state.
    @(negedge clk);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 10'h004; bus.pwdata = 16'hABCD;
    @(negedge clk); bus.penable = 1; rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_pready", bus.pready, 0);
    @(negedge clk); rst = 0; bus.psel = 0; bus.penable = 0;
    rd_reg(IRQ_REG_ENABLE, rd); chk("rst_mid_enable", rd, 16'h0000);
    rd_reg(IRQ_REG_MODE, rd);   chk("rst_mid_mode", rd, 16'h0000);
    rd_reg(IRQ_REG_PENDING, rd); chk("rst_mid_pending", rd, 16'h0000);

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      int act;
      logic [3:0]  o4;
      logic [15:0] wd;
      @(negedge clk);
      src = src ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      act = $urandom_range(0, 99);
      if (act < 2) begin
        rst = 1; @(negedge clk); rst = 0;
      end else if (act < 30) begin
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end else begin
        o4 = 4'($urandom_range(0, 15));
        wd = 16'($urandom);
        if (o4 == 4'd4) wd = 16'($urandom_range(0, 12));
        apb(1'($urandom_range(0, 1)), {o4, 1'b0}, wd, rd, err);
      end
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
